fp_mul_arbiter: RTL
===================

# fp_mul_arbiter

Round-robin arbiter that shares one `fp_multiplier` instance (single-precision, one-cycle registered latency) between `NUM_REQ` independent requesters. Each requester has a valid/ready request channel and a one-entry buffered response channel. The block issues at most one multiply per cycle. It steers each result back to the requester that issued it, and it exposes an issue counter and an idle flag for the surrounding FPU control logic.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 1..16.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high. Also drives the `rst` input of the internal `fp_multiplier`.
- `req_valid`  in  NUM_REQ  request valid, one bit per requester.
- `req_ready`  out  NUM_REQ  grant; at most one bit high per cycle.
- `req_a`  in  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i].
- `req_b`  in  32*NUM_REQ  operand B; same packing as `req_a`.
- `rsp_valid`  out  NUM_REQ  result slot i holds a result.
- `rsp_ready`  in  NUM_REQ  requester i consumes its result.
- `rsp_data`  out  32*NUM_REQ  result for requester i; same packing as `req_a`.
- `ops_count`  out  32  number of issued multiplies; wraps modulo 2^32.
- `idle`  out  1  high when nothing is in flight and all result slots are empty.

## Operation
- **Eligibility.** Requester i is eligible when all of these hold:
  - `req_valid[i]` is high;
  - no operation for i is in flight;
  - result slot i is empty (`rsp_valid[i]`=0).
  - There is no same-cycle bypass: a slot consumed in cycle c makes its requester eligible in cycle c+1, not in c.
- **Arbitration.**
  - The block keeps a round-robin pointer `last` (index of the last granted requester).
  - The grant is the first eligible index found by searching `last+1`, `last+2`, … and wrapping from NUM_REQ-1 back to 0.
  - `req_ready` is the one-hot form of the grant, or zero if no requester is eligible. It is combinational from `req_valid` and state, so requesters must not make `req_valid` depend on `req_ready`.
- **Issue.**
  - The granted requester's `req_a`/`req_b` are muxed combinationally onto the multiplier inputs. Ungranted cycles present zero operands.
  - A handshake is `req_valid[i]` & `req_ready[i]`. On a handshake edge the block sets `inflight_v`, sets `inflight_tag` = i, sets `last` = i, and increments `ops_count` by 1.
  - With no handshake, `inflight_v` is cleared and `last` is unchanged.
- **Writeback.** At the edge after the issue edge, if `inflight_v` is set, the multiplier output is written into slot `inflight_tag` and that slot's `rsp_valid` is set. Eligibility guarantees the target slot is empty, so a result is never overwritten or dropped.
- **Drain.** `rsp_valid[i]` & `rsp_ready[i]` clears slot i at the edge.
  - `rsp_data[i]` holds its value while `rsp_valid[i]` is high.
  - `rsp_data[i]` holds its last value after the slot is drained.
- **Results.** Results are the multiplier's values, passed through unmodified. Examples: NaN operand gives 0xFFFFFFFF; a zero operand gives 0x00000000; infinity gives {sign, 0xFF, 0}.
- **Reset.** Reset, including mid-operation, has this effect:
  - Cleared: `inflight_v`, all `rsp_valid`, all `rsp_data`, and `ops_count`.
  - `last` = NUM_REQ-1, so requester 0 has first priority.
  - Any in-flight operation is discarded.
  - While `rst` is high, `req_ready`=0.

## Timing
- **Reset values:**
  - `req_ready`=0;
  - `rsp_valid`=0;
  - `rsp_data`=0;
  - `ops_count`=0;
  - `idle`=1.
- **Latency.** A handshake in cycle c gives `rsp_valid[i]`=1 in cycle c+2 with the final `rsp_data`.
- **Per-requester throughput.** One operation every 3 cycles when `rsp_ready` is held high:
  - issue in c;
  - result in flight in c+1;
  - result held in c+2;
  - eligible again in c+3.
- **Aggregate throughput.** One issue per cycle whenever at least one requester is eligible. With NUM_REQ≥3 and no backpressure, sustained throughput is 1 issue per cycle.
- **`idle`.** Registered-state decode: `idle` = !`inflight_v` & !(|`rsp_valid`). It is low from the cycle after a handshake until the cycle after the last drain.
- **Backpressure.** A held `rsp_ready[i]`=0 blocks only requester i; other requesters continue to be granted.
- **NUM_REQ=1.** The pointer is constant and grant = eligibility.

## Test plan
- **Single request.** Requester 0 presents a=0x40000000, b=0x40400000 in cycle 0 after reset. Required: `req_ready`=0001 in cycle 0; `rsp_valid[0]`=1 with `rsp_data[0]`=0x40C00000 in cycle 2; `ops_count`=1; `idle`=0 in cycles 1–2; `idle`=1 in cycle 3 after a drain in cycle 2.
- **Round-robin, all requesters.** All 4 requesters hold `req_valid`=1 with `rsp_ready`=1111 and a_i = 1.0 (0x3F800000), b_i = i+1.0. Required:
  - grants 0,1,2,3,0,1,… one per cycle;
  - each `rsp_data` equals its b_i value;
  - `ops_count`=8 after 8 cycles.
- **Partial fairness.** Only requesters 0 and 2 are valid, with `rsp_ready` high. Required: grants alternate 0,2,0,2 (each requester every 3 cycles at most); requesters 1 and 3 are never granted.
- **Backpressure.** Hold `rsp_ready[1]`=0 for 10 cycles while all requesters are valid. Required:
  - `rsp_data[1]` stays stable with `rsp_valid[1]`=1;
  - `req_ready[1]` stays 0;
  - requesters 0, 2 and 3 keep being granted;
  - after `rsp_ready[1]` returns high, requester 1 is regranted within NUM_REQ cycles.
- **Special values.**
  - 0x7FC00000 × 0x3F800000 gives 0xFFFFFFFF.
  - 0x00000000 × 0x40A00000 gives 0x00000000.
  - 0x7F800000 × 0xC0000000 gives 0xFF800000.
- **Reset mid-operation.** Assert `rst` in the cycle after a handshake for requester 2. Required:
  - no `rsp_valid` rises;
  - `ops_count`=0 and `idle`=1 after the reset edge;
  - with all requesters valid after reset, the first grant is requester 0.

Source files
------------

// File: rtl/fp_mul_arbiter_if.sv
// rtl/fp_mul_arbiter_if.sv - requester-side bundle of the shared multiplier arbiter
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [32*NUM_REQ-1:0] rsp_data;
  logic [31:0]           ops_count;
  logic                  idle;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, ops_count, idle
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, ops_count, idle
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin sharing of one registered fp32 multiplier
// Subnormal inputs/outputs flush to zero; rounding is nearest-even.
module fp_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_p
);
  logic        w_sa, w_sb, w_s;
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_ma, w_mb;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [47:0] w_prod;
  logic        w_norm, w_guard, w_sticky, w_round;
  logic [22:0] w_mant;
  logic [23:0] w_mant_r;
  logic [9:0]  w_exp_raw;
  logic [7:0]  w_exp_out;
  logic [31:0] w_p;

  assign w_sa = i_a[31];
  assign w_sb = i_b[31];
  assign w_s  = w_sa ^ w_sb;
  assign w_ea = i_a[30:23];
  assign w_eb = i_b[30:23];
  assign w_ma = i_a[22:0];
  assign w_mb = i_b[22:0];

  assign w_a_nan  = (w_ea == 8'hFF) && (w_ma != '0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_mb != '0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_ma == '0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_mb == '0);
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);

  assign w_prod = {24'b0, 1'b1, w_ma} * {24'b0, 1'b1, w_mb};

  always_comb begin
    w_norm    = w_prod[47];
    w_mant    = w_norm ? w_prod[46:24] : w_prod[45:23];
    w_guard   = w_norm ? w_prod[23] : w_prod[22];
    w_sticky  = w_norm ? (|w_prod[22:0]) : (|w_prod[21:0]);
    w_round   = w_guard & (w_sticky | w_mant[0]);
    w_mant_r  = {1'b0, w_mant} + {23'b0, w_round};
    // Rounding carry renormalises: mantissa becomes zero, exponent bumps.
    w_exp_raw = {2'b0, w_ea} + {2'b0, w_eb} + {9'b0, w_norm} + {9'b0, w_mant_r[23]};
    w_exp_out = w_exp_raw[7:0] - 8'd127;
    w_p       = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_p = 32'hFFFF_FFFF;
    end else if (w_a_inf || w_b_inf) begin
      w_p = {w_s, 8'hFF, 23'b0};
    end else if (w_a_zero || w_b_zero) begin
      w_p = 32'h0000_0000;
    end else if (w_exp_raw >= 10'd382) begin
      w_p = {w_s, 8'hFF, 23'b0};
    end else if (w_exp_raw <= 10'd127) begin
      w_p = 32'h0000_0000;
    end else begin
      w_p = {w_s, w_exp_out, w_mant_r[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_p <= '0;
    end else begin
      o_p <= w_p;
    end
  end
endmodule

module fp_mul_arbiter #(
  parameter int NUM_REQ = 4
) (
  input logic             clk,
  input logic             rst,
  fp_mul_arbiter_if.slave bus
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                  r_inflight_v;
  logic [IDXW-1:0]       r_inflight_tag;
  logic [IDXW-1:0]       r_last;
  logic [31:0]           r_ops_count;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [32*NUM_REQ-1:0] r_rsp_data;

  logic [NUM_REQ-1:0]    w_inflight_mask;
  logic [NUM_REQ-1:0]    w_elig;
  logic                  w_grant_v;
  logic [IDXW-1:0]       w_grant_idx;
  int                    w_idx;
  logic [31:0]           w_mul_a, w_mul_b, w_mul_p;

  always_comb begin
    w_inflight_mask = '0;
    if (r_inflight_v) begin
      w_inflight_mask[r_inflight_tag] = 1'b1;
    end
  end

  // A slot drained this cycle is still full here, so no same-cycle bypass.
  assign w_elig = rst ? '0 : (bus.req_valid & ~w_inflight_mask & ~r_rsp_valid);

  always_comb begin
    w_grant_v   = 1'b0;
    w_grant_idx = '0;
    w_idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_grant_v && w_elig[w_idx]) begin
        w_grant_v   = 1'b1;
        w_grant_idx = IDXW'(w_idx);
      end
    end
  end

  assign bus.req_ready = w_grant_v ? (NUM_REQ'(1) << w_grant_idx) : '0;
  assign w_mul_a = w_grant_v ? bus.req_a[32*w_grant_idx +: 32] : 32'h0;
  assign w_mul_b = w_grant_v ? bus.req_b[32*w_grant_idx +: 32] : 32'h0;

  fp_multiplier u_mul (
    .clk (clk),
    .rst (rst),
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight_v   <= 1'b0;
      r_inflight_tag <= '0;
      r_last         <= IDXW'(NUM_REQ - 1);
      r_ops_count    <= '0;
      r_rsp_valid    <= '0;
      r_rsp_data     <= '0;
    end else begin
      r_inflight_v <= w_grant_v;
      if (w_grant_v) begin
        r_inflight_tag <= w_grant_idx;
        r_last         <= w_grant_idx;
        r_ops_count    <= r_ops_count + 32'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_inflight_v && (r_inflight_tag == IDXW'(i))) begin
          r_rsp_valid[i]          <= 1'b1;
          r_rsp_data[32*i +: 32]  <= w_mul_p;
        end else if (r_rsp_valid[i] && bus.rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.ops_count = r_ops_count;
  assign bus.idle      = !r_inflight_v && !(|r_rsp_valid);
endmodule
